// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, configurable frame format, parity/stop/break
// checking and a first-word fall-through receive FIFO with sticky overrun.
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          reset,
  input  logic                          i_Rx_Serial,
  input  logic                          i_Rd,
  input  logic                          i_Clr_Ovr,
  output logic                          o_Valid,
  output logic [DATA_BITS-1:0]          o_Data,
  output logic                          o_Frame_Err,
  output logic                          o_Parity_Err,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Overrun,
  output logic                          o_Break
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0]    LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_SBIT = 4'(STOP_BITS - 1);
  localparam logic          ODD_SEL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
  } state_t;

  state_t                 state_q, state_d;
  logic                   meta_q, sync_q;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   zero_q, zero_d;
  logic                   ferr_q, ferr_d;
  logic                   brk_q, brk_d;
  logic                   push, push_ferr, push_perr, tick;

  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q;
  logic                   ovr_q;
  logic                   pop, full, wr_en, ovr_set;
  logic [EW-1:0]          head;

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      meta_q    <= 1'b1;
      sync_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      zero_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      meta_q    <= i_Rx_Serial;
      sync_q    <= meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      zero_q    <= zero_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  assign tick = (clk_cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    zero_d    = zero_q;
    ferr_d    = ferr_q;
    brk_d     = 1'b0;
    push      = 1'b0;
    push_ferr = ferr_q;
    push_perr = (PARITY_EN != 0) ? (par_q ^ ODD_SEL) : 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!sync_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_CNT) begin
          clk_cnt_d = '0;
          if (!sync_q) begin
            state_d = S_DATA;
            par_d   = 1'b0;
            zero_d  = 1'b1;
            ferr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          clk_cnt_d = '0;
          shift_d   = {sync_q, shift_q[DATA_BITS-1:1]};
          par_d     = par_q ^ sync_q;
          zero_d    = zero_q & ~sync_q;
          if (bit_cnt_q == LAST_DBIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          clk_cnt_d = '0;
          par_d     = par_q ^ sync_q;
          zero_d    = zero_q & ~sync_q;
          state_d   = S_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          clk_cnt_d = '0;
          push_ferr = ferr_q | ~sync_q;
          ferr_d    = push_ferr;
          // Break only looks at the first stop bit; later stop samples just flag framing.
          if (bit_cnt_q == 4'd0) zero_d = zero_q & ~sync_q;
          if (bit_cnt_q == LAST_SBIT) begin
            bit_cnt_d = '0;
            if (zero_d) begin
              brk_d   = 1'b1;
              state_d = S_BRK_WAIT;
            end else begin
              push    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_BRK_WAIT: begin
        if (sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pop     = i_Rd & (count_q != '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {push_ferr, push_perr, shift_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // A fresh overrun outranks a simultaneous clear.
      if (ovr_set)        ovr_q <= 1'b1;
      else if (i_Clr_Ovr) ovr_q <= 1'b0;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign o_Valid      = (count_q != '0);
  assign o_Data       = head[DATA_BITS-1:0];
  assign o_Parity_Err = head[DATA_BITS];
  assign o_Frame_Err  = head[DATA_BITS+1];
  assign o_Count      = count_q;
  assign o_Overrun    = ovr_q;
  assign o_Break      = brk_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1, 8E1, 7N2) at 16 clocks per bit.
`default_nettype none

module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] rx  = 3'b111;
  logic [2:0] rd  = 3'b000;
  logic [2:0] clr = 3'b000;

  logic [7:0] da, db;
  logic [6:0] dc;
  logic [2:0] vld, fe, pe, ovr, brk;
  logic [2:0] ca, cb, cc;
  logic [8:0] dat [3];
  logic [2:0] cnt [3];

  assign dat[0] = {1'b0, da};
  assign dat[1] = {1'b0, db};
  assign dat[2] = {2'b0, dc};
  assign cnt[0] = ca;
  assign cnt[1] = cb;
  assign cnt[2] = cc;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[0]), .i_Rd(rd[0]), .i_Clr_Ovr(clr[0]),
    .o_Valid(vld[0]), .o_Data(da), .o_Frame_Err(fe[0]), .o_Parity_Err(pe[0]),
    .o_Count(ca), .o_Overrun(ovr[0]), .o_Break(brk[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[1]), .i_Rd(rd[1]), .i_Clr_Ovr(clr[1]),
    .o_Valid(vld[1]), .o_Data(db), .o_Frame_Err(fe[1]), .o_Parity_Err(pe[1]),
    .o_Count(cb), .o_Overrun(ovr[1]), .o_Break(brk[1]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .i_Clock(clk), .reset(reset), .i_Rx_Serial(rx[2]), .i_Rd(rd[2]), .i_Clr_Ovr(clr[2]),
    .o_Valid(vld[2]), .o_Data(dc), .o_Frame_Err(fe[2]), .o_Parity_Err(pe[2]),
    .o_Count(cc), .o_Overrun(ovr[2]), .o_Break(brk[2]));

  always #5 clk = ~clk;

  int brk_cnt = 0;
  always @(posedge clk) if (brk[0]) brk_cnt <= brk_cnt + 1;

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard entries are {frame_err, parity_err, data[8:0]}.
  logic [10:0] sb0 [$];
  logic [10:0] sb1 [$];
  logic [10:0] sb2 [$];

  typedef struct {
    int         which;
    logic [8:0] data;
    logic       par;
    logic [1:0] stops;
    logic [8:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int w, input logic [10:0] e);
    case (w)
      0: sb0.push_back(e);
      1: sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_size(input int w, output int sz);
    case (w)
      0: sz = sb0.size();
      1: sz = sb1.size();
      default: sz = sb2.size();
    endcase
  endtask

  task automatic sb_pop(input int w, output logic [10:0] e);
    case (w)
      0: e = sb0.pop_front();
      1: e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  // Caller is at a negedge; the start bit is driven immediately.
  task automatic send(input int w, input logic [8:0] data, input logic par, input logic [1:0] stops);
    int nbits = (w == 2) ? 7 : 8;
    int nstop = (w == 2) ? 2 : 1;
    rx[w] = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx[w] = data[i];
      repeat (CPB) @(negedge clk);
    end
    if (w == 1) begin
      rx[w] = par;
      repeat (CPB) @(negedge clk);
    end
    for (int s = 0; s < nstop; s++) begin
      rx[w] = stops[s];
      repeat (CPB) @(negedge clk);
    end
    rx[w] = 1'b1;
  endtask

  task automatic read_check(input int w, input string tag);
    int sz;
    logic [10:0] e;
    sb_size(w, sz);
    chk({tag, "_valid"}, int'(vld[w]), 1);
    chk({tag, "_count"}, int'(cnt[w]), sz);
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: got valid entry 0x%0h, expected no entry", tag, dat[w]);
    end else begin
      sb_pop(w, e);
      chk({tag, "_data"}, int'(dat[w]), int'(e[8:0]));
      chk({tag, "_fe"}, int'(fe[w]), int'(e[10]));
      chk({tag, "_pe"}, int'(pe[w]), int'(e[9]));
    end
    rd[w] = 1'b1;
    @(negedge clk);
    rd[w] = 1'b0;
    chk({tag, "_count_after"}, int'(cnt[w]), (sz > 0) ? sz - 1 : 0);
  endtask

  task automatic send_push_a(input logic [7:0] d);
    send(0, {1'b0, d}, 1'b0, 2'b11);
    sb_push(0, {2'b00, 1'b0, d});
  endtask

  initial begin
    int b0;
    logic [10:0] e;

    tbl[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    tbl[2] = '{0, 9'h0FF, 1'b0, 2'b11, 9'h0FF, 1'b0, 1'b0};
    tbl[3] = '{0, 9'h055, 1'b0, 2'b00, 9'h055, 1'b1, 1'b0};
    tbl[4] = '{1, 9'h037, 1'b1, 2'b11, 9'h037, 1'b0, 1'b0};
    tbl[5] = '{1, 9'h037, 1'b0, 2'b11, 9'h037, 1'b0, 1'b1};
    tbl[6] = '{1, 9'h000, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0};
    tbl[7] = '{2, 9'h05A, 1'b0, 2'b01, 9'h05A, 1'b1, 1'b0};
    tbl[8] = '{2, 9'h05A, 1'b0, 2'b11, 9'h05A, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    chk("rst_valid", int'(vld[0]), 0);
    chk("rst_data", int'(dat[0]), 0);
    chk("rst_fe", int'(fe[0]), 0);
    chk("rst_pe", int'(pe[0]), 0);
    chk("rst_count", int'(cnt[0]), 0);
    chk("rst_ovr", int'(ovr[0]), 0);
    chk("rst_brk", int'(brk[0]), 0);

    for (int i = 0; i < 9; i++) begin
      send(tbl[i].which, tbl[i].data, tbl[i].par, tbl[i].stops);
      sb_push(tbl[i].which, {tbl[i].exp_fe, tbl[i].exp_pe, tbl[i].exp_data});
      read_check(tbl[i].which, $sformatf("vec%0d", i));
    end

    // Glitch shorter than half a bit must not start a frame.
    rx[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_count", int'(cnt[0]), 0);
    send_push_a(8'h3C);
    read_check(0, "post_glitch");

    // Long low line: one break pulse, nothing queued, then normal reception.
    b0 = brk_cnt;
    rx[0] = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    rx[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_pulses", brk_cnt - b0, 1);
    chk("break_count", int'(cnt[0]), 0);
    send_push_a(8'h81);
    read_check(0, "post_break");

    // Five frames into a four-deep FIFO: fifth dropped, overrun sticky.
    for (int v = 1; v <= 5; v++) begin
      send(0, 9'(v), 1'b0, 2'b11);
      if (v <= 4) sb_push(0, {2'b00, 9'(v)});
    end
    chk("ovr_count", int'(cnt[0]), 4);
    chk("ovr_flag", int'(ovr[0]), 1);
    for (int k = 0; k < 4; k++) read_check(0, $sformatf("ovr_rd%0d", k));
    chk("ovr_hold", int'(ovr[0]), 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovr_clr", int'(ovr[0]), 0);

    // Same again, but a pop lands exactly on the fifth push cycle.
    for (int v = 1; v <= 4; v++) send_push_a(8'(v));
    fork
      send(0, 9'h005, 1'b0, 2'b11);
      begin
        repeat (10 * CPB - 6) @(negedge clk);
        sb_pop(0, e);
        chk("simul_head", int'(dat[0]), int'(e[8:0]));
        rd[0] = 1'b1;
        @(negedge clk);
        rd[0] = 1'b0;
      end
    join
    sb_push(0, {2'b00, 9'h005});
    chk("simul_count", int'(cnt[0]), 4);
    chk("simul_ovr", int'(ovr[0]), 0);
    for (int k = 0; k < 4; k++) read_check(0, $sformatf("simul_rd%0d", k));

    // Reset in the middle of data bit 3 while one entry is already queued.
    send_push_a(8'hA5);
    fork
      send(0, 9'h0FD, 1'b0, 2'b11);
      begin
        repeat (4 * CPB + 8) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb0.delete();
        chk("mid_rst_valid", int'(vld[0]), 0);
        chk("mid_rst_data", int'(dat[0]), 0);
        chk("mid_rst_count", int'(cnt[0]), 0);
        chk("mid_rst_fe", int'(fe[0]), 0);
      end
    join
    repeat (4) @(negedge clk);
    chk("mid_rst_nopush", int'(cnt[0]), 0);
    send_push_a(8'h3C);
    read_check(0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a configurable frame format: 5–9 data bits, optional even/odd parity, and 1 or 2 stop bits. It adds stop-bit validation, parity checking, break detection and a small receive FIFO with overrun reporting. It sits between the external RX pin and the CPU's memory-mapped IO. It replaces single-cycle data-valid pulses with a pop-style interface, so bytes are not lost while the CPU is busy.

Parameters:
CLKS_PER_BIT, 217, clock cycles per bit (i_Clock frequency / baud rate); legal range 4..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits checked; 1 or 2.
FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
i_Clock  input  1  system clock
reset  input  1  synchronous, active-high reset
i_Rx_Serial  input  1  asynchronous serial line; idles high
i_Rd  input  1  pop the head entry; ignored when o_Valid=0
i_Clr_Ovr  input  1  clears o_Overrun
o_Valid  output  1  FIFO not empty
o_Data  output  DATA_BITS  head entry data, first-word fall-through
o_Frame_Err  output  1  head entry had a stop bit sampled 0
o_Parity_Err  output  1  head entry had a parity mismatch (always 0 when PARITY_EN=0)
o_Count  output  clog2(FIFO_DEPTH)+1  number of FIFO entries
o_Overrun  output  1  sticky: a frame was dropped because the FIFO was full
o_Break  output  1  one-cycle pulse on break detection

Behaviour:
- Reset: all state is cleared on i_Clock when reset=1.
  - Synchroniser flops reset to 1; FSM goes to IDLE; counters and FIFO pointers reset to 0.
  - Outputs after reset: o_Valid=0, o_Data=0, o_Frame_Err=0, o_Parity_Err=0, o_Count=0, o_Overrun=0, o_Break=0.
  - Reset mid-frame abandons the frame; no partial entry is written.
- Input synchroniser: 2-flop, so the FSM sees the line delayed by 2 cycles.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- Bit counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every sample.
- IDLE:
  - Synchronised line = 0 -> go to START with counter=0.
- START:
  - When counter reaches (CLKS_PER_BIT-1)/2, sample the line.
  - Sample 0 -> go to DATA.
  - Sample 1 -> treat as a glitch and return to IDLE; nothing is pushed.
- DATA:
  - Sample at counter = CLKS_PER_BIT-1, LSB first, into a shift register.
  - After DATA_BITS samples -> go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - One sample; parity_err = XOR(data bits, parity bit) XOR PARITY_ODD.
- STOP:
  - STOP_BITS samples; frame_err = 1 if any stop sample is 0.
  - Processing happens in the cycle of the last stop sample.
- Break: all data bits, the parity bit (if any) and the first stop bit are 0.
  - o_Break pulses for 1 cycle; no FIFO push; go to BRK_WAIT.
  - BRK_WAIT returns to IDLE only once the synchronised line = 1.
- Non-break frame completion:
  - Push {frame_err, parity_err, data}, then go to IDLE in the same cycle, so back-to-back frames are received.
  - The entry is visible on the outputs (o_Valid, o_Data) on the cycle after the last stop sample.
- FIFO:
  - Pop occurs when i_Rd=1 and o_Valid=1; o_Data/o_Frame_Err/o_Parity_Err advance to the next entry on the following cycle.
  - Push while full and not popping -> the new frame is dropped and o_Overrun is set.
  - Push and pop in the same cycle while full -> both succeed, o_Count unchanged, no overrun.
  - Push and pop in the same cycle while empty is impossible (pop is ignored when o_Valid=0).
  - Pointers wrap modulo FIFO_DEPTH; o_Count distinguishes full from empty.
- o_Overrun: cleared by i_Clr_Ovr. If i_Clr_Ovr and a new overrun occur in the same cycle, the overrun wins (o_Overrun stays 1).
- Output data: when empty, o_Data shows the stale RAM entry; its value is don't-care while o_Valid=0.

Test Plan:
- Basic receive (CLKS_PER_BIT=16, 8N1): send 0xA5 -> o_Valid=1 after the stop midpoint; o_Data=0xA5; o_Frame_Err=0; o_Parity_Err=0; o_Count=1. Pulse i_Rd -> o_Valid=0, o_Count=0.
- Parity check (PARITY_EN=1, even): send 0x37 with parity bit 1 -> o_Data=0x37, o_Parity_Err=0. Send 0x37 with parity bit 0 -> o_Parity_Err=1.
- Glitch rejection: hold line low for 4 cycles, then high -> no push; FSM back in IDLE. A following 0x3C frame is received correctly.
- Framing and break errors:
  - Send 0x55 with stop bit 0 -> entry pushed with o_Frame_Err=1.
  - Hold line low for 30 bit times -> exactly one o_Break pulse, no push. After the line returns high, 0x81 is received cleanly.
- Overrun (FIFO_DEPTH=4): send 0x01..0x05 with no reads -> o_Count=4, o_Overrun=1; reads return 01,02,03,04. i_Clr_Ovr -> o_Overrun=0.
  - Repeat with i_Rd asserted in the 5th push cycle -> o_Overrun stays 0.
- Reset and format variants:
  - Assert reset during data bit 3 -> all outputs 0; the next frame 0x3C is received correctly.
  - With DATA_BITS=7, STOP_BITS=2: send 0x5A with the second stop bit 0 -> o_Frame_Err=1.
